// File: rtl/vrf_bank_requester.sv
// rtl/vrf_bank_requester.sv - VRF bank initiator: credit-throttled readers plus one write stream,
// arbitrated per bank (write first, then round-robin) and issued through a registered request stage.
module vrf_bank_requester #(
  parameter int NrBanks    = 8,
  parameter int NrReaders  = 4,
  parameter int VAddrWidth = 16,
  parameter int QueueDepth = 4,
  parameter int LenWidth   = 12,
  localparam int BankSel    = $clog2(NrBanks),
  localparam int BAddrWidth = VAddrWidth - BankSel,
  localparam int QIdxWidth  = $clog2(NrReaders),
  localparam int CntWidth   = $clog2(QueueDepth + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrReaders-1:0]              cmd_valid_i,
  output logic [NrReaders-1:0]              cmd_ready_o,
  input  logic [NrReaders*VAddrWidth-1:0]   cmd_addr_i,
  input  logic [NrReaders*LenWidth-1:0]     cmd_len_i,
  output logic [NrReaders-1:0]              cmd_done_o,
  input  logic [NrReaders-1:0]              credit_ret_i,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [VAddrWidth-1:0]             wr_addr_i,
  input  logic [63:0]                       wr_data_i,
  input  logic [7:0]                        wr_be_i,
  output logic [NrBanks-1:0]                req_o,
  output logic [NrBanks*BAddrWidth-1:0]     addr_o,
  output logic [NrBanks-1:0]                wen_o,
  output logic [NrBanks*64-1:0]             wdata_o,
  output logic [NrBanks*8-1:0]              be_o,
  output logic [NrBanks*QIdxWidth-1:0]      tgt_opqueue_o
);

  typedef enum logic {IDLE, READ} state_e;

  state_e state_q [NrReaders];
  state_e state_d [NrReaders];
  logic [NrReaders-1:0][VAddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [NrReaders-1:0][LenWidth-1:0]   remaining_q, remaining_d;
  logic [NrReaders-1:0][CntWidth-1:0]   credit_q, credit_d;
  logic [NrReaders-1:0]                 done_q, done_d;
  logic [NrBanks-1:0][QIdxWidth-1:0]    rr_q, rr_d;

  logic [NrReaders-1:0] bid;
  logic [NrReaders-1:0] grant;

  logic [NrBanks-1:0]                 req_q, req_d;
  logic [NrBanks-1:0]                 wen_q, wen_d;
  logic [NrBanks-1:0][BAddrWidth-1:0] addr_q, addr_d;
  logic [NrBanks-1:0][63:0]           wdata_q, wdata_d;
  logic [NrBanks-1:0][7:0]            be_q, be_d;
  logic [NrBanks-1:0][QIdxWidth-1:0]  tgt_q, tgt_d;

  always_comb begin
    for (int r = 0; r < NrReaders; r++) begin
      bid[r] = (state_q[r] == READ) && (credit_q[r] != '0);
    end
  end

  // Per-bank arbitration; req_d doubles as the "already granted" flag inside the RR scan.
  always_comb begin
    logic [QIdxWidth-1:0] idx;
    int                   sum;
    req_d   = '0;
    wen_d   = '0;
    addr_d  = '0;
    wdata_d = '0;
    be_d    = '0;
    tgt_d   = '0;
    rr_d    = rr_q;
    grant   = '0;
    idx     = '0;
    sum     = 0;
    for (int b = 0; b < NrBanks; b++) begin
      if (wr_valid_i && (wr_addr_i[BankSel-1:0] == BankSel'(b))) begin
        req_d[b]   = 1'b1;
        wen_d[b]   = 1'b1;
        addr_d[b]  = wr_addr_i[VAddrWidth-1:BankSel];
        wdata_d[b] = wr_data_i;
        be_d[b]    = wr_be_i;
      end else begin
        for (int k = 0; k < NrReaders; k++) begin
          sum = int'(rr_q[b]) + k;
          if (sum >= NrReaders) sum = sum - NrReaders;
          idx = QIdxWidth'(sum);
          if (!req_d[b] && bid[idx] && (cur_addr_q[idx][BankSel-1:0] == BankSel'(b))) begin
            req_d[b]   = 1'b1;
            addr_d[b]  = cur_addr_q[idx][VAddrWidth-1:BankSel];
            tgt_d[b]   = idx;
            grant[idx] = 1'b1;
            rr_d[b]    = (idx == QIdxWidth'(NrReaders - 1)) ? '0 : idx + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NrReaders; r++) begin
      state_d[r]     = state_q[r];
      cur_addr_d[r]  = cur_addr_q[r];
      remaining_d[r] = remaining_q[r];
      credit_d[r]    = credit_q[r];
      done_d[r]      = 1'b0;
      if ((state_q[r] == IDLE) && cmd_valid_i[r]) begin
        if (cmd_len_i[r*LenWidth +: LenWidth] == '0) begin
          done_d[r] = 1'b1;
        end else begin
          state_d[r]     = READ;
          cur_addr_d[r]  = cmd_addr_i[r*VAddrWidth +: VAddrWidth];
          remaining_d[r] = cmd_len_i[r*LenWidth +: LenWidth];
        end
      end
      if (grant[r]) begin
        cur_addr_d[r]  = cur_addr_q[r] + 1'b1;
        remaining_d[r] = remaining_q[r] - 1'b1;
        if (remaining_q[r] == LenWidth'(1)) begin
          state_d[r] = IDLE;
          done_d[r]  = 1'b1;
        end
      end
      // A return while full is illegal; hold at QueueDepth rather than wrap.
      if (grant[r] && !credit_ret_i[r]) begin
        credit_d[r] = credit_q[r] - 1'b1;
      end else if (!grant[r] && credit_ret_i[r] && (credit_q[r] != CntWidth'(QueueDepth))) begin
        credit_d[r] = credit_q[r] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NrReaders; r++) begin
        state_q[r] <= IDLE;
      end
      cur_addr_q  <= '0;
      remaining_q <= '0;
      credit_q    <= {NrReaders{CntWidth'(QueueDepth)}};
      done_q      <= '0;
      rr_q        <= '0;
      req_q       <= '0;
      wen_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      tgt_q       <= '0;
    end else begin
      for (int r = 0; r < NrReaders; r++) begin
        state_q[r] <= state_d[r];
      end
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      credit_q    <= credit_d;
      done_q      <= done_d;
      rr_q        <= rr_d;
      req_q       <= req_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      tgt_q       <= tgt_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NrReaders; r++) begin
      cmd_ready_o[r] = (state_q[r] == IDLE);
    end
  end

  assign cmd_done_o    = done_q;
  assign wr_ready_o    = wr_valid_i;
  assign req_o         = req_q;
  assign wen_o         = wen_q;
  assign addr_o        = addr_q;
  assign wdata_o       = wdata_q;
  assign be_o          = be_q;
  assign tgt_opqueue_o = tgt_q;

  for (genvar r = 0; r < NrReaders; r++) begin : g_credit_chk
    credit_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
      !(credit_ret_i[r] && !grant[r] && (credit_q[r] == CntWidth'(QueueDepth))));
  end

endmodule

// File: tb/tb_vrf_bank_requester.sv
// tb/tb_vrf_bank_requester.sv - directed self-checking bench for vrf_bank_requester.
module tb_vrf_bank_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cmd_valid = '0;
  logic [3:0]  cmd_ready;
  logic [63:0] cmd_addr = '0;
  logic [47:0] cmd_len = '0;
  logic [3:0]  cmd_done;
  logic [3:0]  credit_ret = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_be = '0;
  logic [7:0]  req_o;
  logic [103:0] addr_o;
  logic [7:0]  wen_o;
  logic [511:0] wdata_o;
  logic [63:0] be_o;
  logic [15:0] tgt_o;

  int checks = 0;
  int failures = 0;
  int rd_cnt [4] = '{default: 0};
  int done_cnt [4] = '{default: 0};

  vrf_bank_requester dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_done_o(cmd_done),
    .credit_ret_i(credit_ret),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_be_i(wr_be),
    .req_o(req_o), .addr_o(addr_o), .wen_o(wen_o), .wdata_o(wdata_o),
    .be_o(be_o), .tgt_opqueue_o(tgt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (req_o[b] && !wen_o[b]) rd_cnt[tgt_o[b*2 +: 2]] += 1;
    end
    for (int r = 0; r < 4; r++) begin
      if (cmd_done[r]) done_cnt[r] += 1;
    end
  end

  function automatic logic [12:0] baddr(input int b);
    return addr_o[b*13 +: 13];
  endfunction

  function automatic logic [1:0] btgt(input int b);
    return tgt_o[b*2 +: 2];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = '0;
    credit_ret = '0;
    wr_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_cmd(input int r, input logic [15:0] a, input logic [11:0] l);
    cmd_valid[r] = 1'b1;
    cmd_addr[r*16 +: 16] = a;
    cmd_len[r*12 +: 12] = l;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_o !== 8'h00) begin failures++; $display("FAIL reset_req got=%h exp=00", req_o); end
    checks++; if ({wen_o, be_o, tgt_o, addr_o} !== '0) begin failures++; $display("FAIL reset_fields got wen=%h be=%h tgt=%h", wen_o, be_o, tgt_o); end
    checks++; if (wdata_o !== '0) begin failures++; $display("FAIL reset_wdata nonzero"); end
    checks++; if (cmd_ready !== 4'hF) begin failures++; $display("FAIL reset_ready got=%h exp=F", cmd_ready); end
    checks++; if (cmd_done !== 4'h0) begin failures++; $display("FAIL reset_done got=%h exp=0", cmd_done); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
  endtask

  task automatic test_stream();
    do_reset();
    set_cmd(0, 16'h0010, 12'd8);
    step();
    cmd_valid = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      credit_ret[0] = 1'b1;
      checks++; if (req_o !== 8'(1 << i)) begin failures++; $display("FAIL stream_req[%0d] got=%h exp=%h", i, req_o, 8'(1 << i)); end
      checks++; if (baddr(i) !== 13'h002 || btgt(i) !== 2'd0 || wen_o !== 8'h00) begin
        failures++; $display("FAIL stream_fields[%0d] got addr=%h tgt=%0d wen=%h exp addr=002 tgt=0 wen=00", i, baddr(i), btgt(i), wen_o);
      end
      checks++; if (cmd_done[0] !== (i == 7)) begin failures++; $display("FAIL stream_done[%0d] got=%b exp=%b", i, cmd_done[0], (i == 7)); end
    end
    step();
    credit_ret = '0;
    checks++; if (req_o !== 8'h00 || cmd_done !== 4'h0) begin failures++; $display("FAIL stream_end got req=%h done=%h exp 00/0", req_o, cmd_done); end
    checks++; if (cmd_ready[0] !== 1'b1) begin failures++; $display("FAIL stream_ready got=%b exp=1", cmd_ready[0]); end
  endtask

  task automatic test_credit_stall();
    int rb, db;
    do_reset();
    rb = rd_cnt[1];
    db = done_cnt[1];
    set_cmd(1, 16'h0020, 12'd6);
    step();
    cmd_valid = '0;
    repeat (10) step();
    checks++; if (rd_cnt[1] - rb !== 4) begin failures++; $display("FAIL stall_reads got=%0d exp=4", rd_cnt[1] - rb); end
    checks++; if (done_cnt[1] - db !== 0 || cmd_ready[1] !== 1'b0) begin failures++; $display("FAIL stall_busy got done=%0d ready=%b exp 0/0", done_cnt[1] - db, cmd_ready[1]); end
    credit_ret[1] = 1'b1; step();
    credit_ret[1] = 1'b0; step();
    credit_ret[1] = 1'b1; step();
    credit_ret[1] = 1'b0;
    repeat (8) step();
    checks++; if (rd_cnt[1] - rb !== 6) begin failures++; $display("FAIL stall_resume_reads got=%0d exp=6", rd_cnt[1] - rb); end
    checks++; if (done_cnt[1] - db !== 1 || cmd_ready[1] !== 1'b1) begin failures++; $display("FAIL stall_done got done=%0d ready=%b exp 1/1", done_cnt[1] - db, cmd_ready[1]); end
  endtask

  task automatic test_bank_conflict();
    logic [1:0] exp_t;
    do_reset();
    for (int r = 0; r < 3; r++) set_cmd(r, 16'h0000, 12'd1);
    step();
    cmd_valid = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_t = 2'(i);
      checks++; if (req_o !== 8'h01 || btgt(0) !== exp_t) begin failures++; $display("FAIL conflict_r1[%0d] got req=%h tgt=%0d exp req=01 tgt=%0d", i, req_o, btgt(0), exp_t); end
      checks++; if (cmd_done !== 4'(1 << i)) begin failures++; $display("FAIL conflict_done[%0d] got=%h exp=%h", i, cmd_done, 4'(1 << i)); end
    end
    step();
    for (int r = 0; r < 4; r++) set_cmd(r, 16'h0000, 12'd1);
    step();
    cmd_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_t = 2'((3 + i) % 4);
      checks++; if (req_o !== 8'h01 || btgt(0) !== exp_t) begin failures++; $display("FAIL conflict_r2[%0d] got req=%h tgt=%0d exp req=01 tgt=%0d", i, req_o, btgt(0), exp_t); end
    end
  endtask

  task automatic test_write_priority();
    do_reset();
    set_cmd(0, 16'h0003, 12'd1);
    step();
    cmd_valid = '0;
    wr_valid = 1'b1;
    wr_addr = 16'h0003;
    wr_data = 64'hDEAD_BEEF_0123_4567;
    wr_be = 8'hFF;
    #1;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", wr_ready); end
    step();
    wr_valid = 1'b0;
    checks++; if (req_o !== 8'h08 || wen_o !== 8'h08) begin failures++; $display("FAIL wr_issue got req=%h wen=%h exp 08/08", req_o, wen_o); end
    checks++; if (be_o[31:24] !== 8'hFF || wdata_o[255:192] !== 64'hDEAD_BEEF_0123_4567 || baddr(3) !== 13'h0) begin
      failures++; $display("FAIL wr_fields got be=%h data=%h addr=%h", be_o[31:24], wdata_o[255:192], baddr(3));
    end
    checks++; if (cmd_done !== 4'h0) begin failures++; $display("FAIL wr_reader_wait got done=%h exp=0", cmd_done); end
    step();
    checks++; if (req_o !== 8'h08 || wen_o !== 8'h00 || be_o !== '0 || btgt(3) !== 2'd0) begin
      failures++; $display("FAIL wr_then_read got req=%h wen=%h be=%h tgt=%0d exp 08/00/0/0", req_o, wen_o, be_o, btgt(3));
    end
    checks++; if (cmd_done !== 4'h1) begin failures++; $display("FAIL wr_then_done got=%h exp=1", cmd_done); end
  endtask

  task automatic test_boundaries();
    int rb, db;
    rb = rd_cnt[2];
    set_cmd(2, 16'h0100, 12'd0);
    step();
    cmd_valid = '0;
    checks++; if (cmd_done !== 4'h4 || cmd_ready[2] !== 1'b1) begin failures++; $display("FAIL len0_done got done=%h ready=%b exp 4/1", cmd_done, cmd_ready[2]); end
    step();
    checks++; if (cmd_done !== 4'h0) begin failures++; $display("FAIL len0_pulse got=%h exp=0", cmd_done); end
    repeat (3) step();
    checks++; if (rd_cnt[2] - rb !== 0) begin failures++; $display("FAIL len0_noreq got=%0d exp=0", rd_cnt[2] - rb); end

    set_cmd(0, 16'hFFFF, 12'd2);
    step();
    cmd_valid = '0;
    step();
    checks++; if (req_o !== 8'h80 || baddr(7) !== 13'h1FFF) begin failures++; $display("FAIL wrap_first got req=%h addr=%h exp 80/1FFF", req_o, baddr(7)); end
    step();
    checks++; if (req_o !== 8'h01 || baddr(0) !== 13'h0000 || cmd_done !== 4'h1) begin
      failures++; $display("FAIL wrap_second got req=%h addr=%h done=%h exp 01/0000/1", req_o, baddr(0), cmd_done);
    end

    do_reset();
    rb = rd_cnt[3];
    db = done_cnt[3];
    set_cmd(3, 16'h0040, 12'd8);
    step();
    cmd_valid = '0;
    step();
    credit_ret[3] = 1'b1;
    repeat (3) step();
    credit_ret[3] = 1'b0;
    repeat (8) step();
    checks++; if (rd_cnt[3] - rb !== 7 || done_cnt[3] - db !== 0) begin failures++; $display("FAIL grant_ret_hold got reads=%0d done=%0d exp 7/0", rd_cnt[3] - rb, done_cnt[3] - db); end
    credit_ret[3] = 1'b1;
    step();
    credit_ret[3] = 1'b0;
    repeat (4) step();
    checks++; if (rd_cnt[3] - rb !== 8 || done_cnt[3] - db !== 1) begin failures++; $display("FAIL grant_ret_finish got reads=%0d done=%0d exp 8/1", rd_cnt[3] - rb, done_cnt[3] - db); end
  endtask

  task automatic test_reset_mid_cmd();
    int rb, db;
    do_reset();
    rb = rd_cnt[2];
    db = done_cnt[2];
    set_cmd(2, 16'h0000, 12'd5);
    step();
    cmd_valid = '0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++; if (req_o !== 8'h00 || cmd_ready !== 4'hF || cmd_done !== 4'h0) begin
      failures++; $display("FAIL midrst_state got req=%h ready=%h done=%h exp 00/F/0", req_o, cmd_ready, cmd_done);
    end
    rst = 1'b0;
    repeat (6) step();
    checks++; if (rd_cnt[2] - rb !== 2 || done_cnt[2] - db !== 0) begin failures++; $display("FAIL midrst_discard got reads=%0d done=%0d exp 2/0", rd_cnt[2] - rb, done_cnt[2] - db); end
    rb = rd_cnt[2];
    set_cmd(2, 16'h0008, 12'd6);
    step();
    cmd_valid = '0;
    repeat (10) step();
    checks++; if (rd_cnt[2] - rb !== 4) begin failures++; $display("FAIL midrst_credits got=%0d exp=4", rd_cnt[2] - rb); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit_stall();
    test_bank_conflict();
    test_write_priority();
    test_boundaries();
    test_reset_mid_cmd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vrf_bank_requester.md
Name: vrf_bank_requester

Overview:
- Initiator side of the lane VRF bank interface: turns per-operand-queue read commands and a single write stream into per-bank req/addr/wen/wdata/be/tgt_opqueue requests.
- Bank ports connect directly to the lane vector register file.
- Word addresses are interleaved across banks. Reads are throttled by per-queue credits so no operand queue overflows.
- Per-bank arbitration: write first, then round-robin among readers.

Parameters:
- NrBanks, 8, number of VRF banks, power of two ≥2.
- NrReaders, 4, number of operand queues / read channels; reader r targets opqueue index r.
- VAddrWidth, 16, width of the lane word address.
- QueueDepth, 4, operand-queue capacity in words; initial credit count per reader.
- LenWidth, 12, width of the read command word count.
- Derived: BankSel=$clog2(NrBanks), BAddrWidth=VAddrWidth-BankSel, QIdxWidth=$clog2(NrReaders), CntWidth=$clog2(QueueDepth+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  NrReaders  read command valid per reader
- cmd_ready_o  out  NrReaders  command accepted (reader in IDLE)
- cmd_addr_i  in  NrReaders*VAddrWidth  first word address
- cmd_len_i  in  NrReaders*LenWidth  number of words to read
- cmd_done_o  out  NrReaders  one-cycle pulse after the last word of a command is granted
- credit_ret_i  in  NrReaders  one word popped from operand queue r
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted
- wr_addr_i  in  VAddrWidth  write word address
- wr_data_i  in  64  write data (elen_t)
- wr_be_i  in  8  write byte enables
- req_o  out  NrBanks  bank request
- addr_o  out  NrBanks*BAddrWidth  bank-local address
- wen_o  out  NrBanks  write enable
- wdata_o  out  NrBanks*64  write data
- be_o  out  NrBanks*8  byte enables
- tgt_opqueue_o  out  NrBanks*QIdxWidth  target queue for reads

Behaviour:
- Address map: bank = addr[BankSel-1:0]; bank-local addr = addr[VAddrWidth-1:BankSel].
- Reader FSM per channel:
  - States IDLE, READ.
  - cmd_ready_o[r] = (state==IDLE).
  - Handshake cmd_valid&&ready: latch addr/len.
  - len==0: stay IDLE, pulse cmd_done_o next cycle, issue no request.
  - Otherwise go to READ with cur_addr=addr, remaining=len.
- A reader in READ bids for bank(cur_addr) iff credit[r]>0.
- Per-bank arbitration each cycle:
  - A valid write to that bank always wins.
  - Otherwise a round-robin arbiter picks among bidding readers.
  - Each bank's RR pointer advances only on a reader grant, to the index after the winner.
  - Reset pointer: 0.
- wr_ready_o = wr_valid_i, combinational (writes never stall). A reader losing to a write retries next cycle.
- On reader grant:
  - credit[r]--, cur_addr++ (wraps modulo 2^VAddrWidth), remaining--.
  - When remaining becomes 0: go to IDLE and pulse cmd_done_o[r] the following cycle.
  - A new command is acceptable the cycle after returning to IDLE.
- Credits:
  - credit[r] += credit_ret_i[r].
  - Grant and return in the same cycle: net unchanged.
  - Credit never exceeds QueueDepth. A return at QueueDepth is an error (assertion); the counter saturates.
- Output register stage:
  - Arbitration results are registered. A grant in cycle t drives req_o/addr_o/wen_o/wdata_o/be_o/tgt_opqueue_o in cycle t+1 for one cycle.
  - Read data then returns from the VRF at t+2.
  - Ungranted banks drive req_o=0; other fields hold 0.
- One reader is granted at most one bank per cycle, since each reader bids for a single bank.
- Reset (any cycle, including mid-command):
  - All FSMs to IDLE; credits to QueueDepth; RR pointers to 0.
  - All outputs 0, except cmd_ready_o = all ones after reset deasserts.
  - In-flight commands are discarded with no done pulse.

Test Plan:
1. Reader 0 command addr=0x0010, len=8, no contention.
   - Grants in 8 consecutive cycles on banks 0..7 with addr_o=0x002.
   - req_o visible one cycle after each grant; tgt_opqueue_o=0.
   - cmd_done_o[0] pulses after the 8th grant.
2. Credit stall: reader 1 len=6 with no credit_ret.
   - Exactly 4 requests, then stall.
   - Two credit_ret_i[1] pulses yield the remaining 2 requests, then done.
3. Bank conflict: readers 0,1,2 all start at addr 0x0000, len=1, same cycle.
   - Bank 0 grants in order 0,1,2 over 3 cycles.
   - Repeat: the RR pointer continues from 3.
4. Write priority: wr_valid_i with addr 0x0003 while reader 0 bids for bank 3.
   - Write issued on bank 3 (wen_o[3]=1, be_o=0xFF); reader 0 granted next cycle.
5. Boundaries:
   - len=0: done pulse, no req_o.
   - addr=0xFFFF, len=2: wraps to 0x0000 (bank 7 then bank 0).
   - Simultaneous grant+credit_ret holds credit.
6. Reset asserted mid-command (reader 2, 3 words remaining).
   - Next cycle: req_o=0, cmd_ready_o all 1, credits 4.
   - No cmd_done_o.
